// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: synchronises PLL lock and a bouncy button, releases
// PORESETn then HRESETn in order, and records the cause of the latest reset.
module rst_seq_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int POR_CYCLES      = 255,
  parameter int SYS_CYCLES      = 16,
  parameter bit LOCKUP_RESET    = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCKED,
  input  logic       BTN,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUP,
  output logic       PORESETn,
  output logic       HRESETn,
  output logic [3:0] RESET_CAUSE,
  output logic       SEQ_BUSY
);
  localparam int CNT_MAX = (POR_CYCLES > SYS_CYCLES) ? POR_CYCLES : SYS_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] CAUSE_POR  = 4'b0001;
  localparam logic [3:0] CAUSE_LOCK = 4'b0010;
  localparam logic [3:0] CAUSE_BTN  = 4'b0100;
  localparam logic [3:0] CAUSE_SYS  = 4'b1000;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    POR_CNT,
    SYS_CNT,
    RUN,
    BTN_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   btn_db_q, btn_db_d;
  logic                   btn_db_prev_q, btn_db_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   por_n_q, por_n_d;
  logic                   hrst_n_q, hrst_n_d;
  logic [3:0]             cause_q, cause_d;
  logic                   busy_q, busy_d;

  logic lock_s, btn_s, btn_press, sys_req;

  assign lock_s    = lock_sync_q[SYNC_STAGES-1];
  assign btn_s     = btn_sync_q[SYNC_STAGES-1];
  assign btn_press = btn_db_q & ~btn_db_prev_q;
  assign sys_req   = SYSRESETREQ | (LOCKUP & LOCKUP_RESET);

  always_comb begin
    lock_sync_d   = {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCKED};
    btn_sync_d    = {btn_sync_q[SYNC_STAGES-2:0], BTN};
    btn_db_d      = btn_db_q;
    btn_db_prev_d = btn_db_q;
    db_cnt_d      = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_s;
      else                     db_cnt_d = db_cnt_q + DB_W'(1);
    end

    state_d  = state_q;
    cnt_d    = cnt_q;
    por_n_d  = por_n_q;
    hrst_n_d = hrst_n_q;
    cause_d  = cause_q;

    // Lock loss outranks the button, which outranks core requests.
    if (!lock_s && state_q != WAIT_LOCK && state_q != BTN_HOLD) begin
      state_d  = WAIT_LOCK;
      cnt_d    = '0;
      por_n_d  = 1'b0;
      hrst_n_d = 1'b0;
      cause_d  = CAUSE_LOCK;
    end else if (btn_press && state_q != BTN_HOLD) begin
      state_d  = BTN_HOLD;
      cnt_d    = '0;
      por_n_d  = 1'b0;
      hrst_n_d = 1'b0;
      cause_d  = CAUSE_BTN;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          por_n_d  = 1'b0;
          hrst_n_d = 1'b0;
          cnt_d    = '0;
          if (lock_s) state_d = POR_CNT;
        end
        POR_CNT: begin
          if (cnt_q == POR_LAST) begin
            por_n_d = 1'b1;
            cnt_d   = '0;
            state_d = SYS_CNT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SYS_CNT: begin
          if (cnt_q == SYS_LAST) begin
            hrst_n_d = 1'b1;
            cnt_d    = '0;
            state_d  = RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (sys_req) begin
            hrst_n_d = 1'b0;
            cause_d  = CAUSE_SYS;
            cnt_d    = '0;
            state_d  = SYS_CNT;
          end
        end
        BTN_HOLD: begin
          por_n_d  = 1'b0;
          hrst_n_d = 1'b0;
          cnt_d    = '0;
          if (!btn_db_q) state_d = WAIT_LOCK;
        end
        default: begin
          state_d  = WAIT_LOCK;
          por_n_d  = 1'b0;
          hrst_n_d = 1'b0;
          cnt_d    = '0;
        end
      endcase
    end

    busy_d = (state_d != RUN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= WAIT_LOCK;
      lock_sync_q   <= '0;
      btn_sync_q    <= '0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      cnt_q         <= '0;
      por_n_q       <= 1'b0;
      hrst_n_q      <= 1'b0;
      cause_q       <= CAUSE_POR;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      lock_sync_q   <= lock_sync_d;
      btn_sync_q    <= btn_sync_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      cnt_q         <= cnt_d;
      por_n_q       <= por_n_d;
      hrst_n_q      <= hrst_n_d;
      cause_q       <= cause_d;
      busy_q        <= busy_d;
    end
  end

  assign PORESETn    = por_n_q;
  assign HRESETn     = hrst_n_q;
  assign RESET_CAUSE = cause_q;
  assign SEQ_BUSY    = busy_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed stimulus with expected output snapshots queued
// per clock edge; unit 1 is a second instance with LOCKUP_RESET disabled.
module tb_rst_seq_ctrl;
  logic clk = 1'b0;
  logic RESET, PLL_LOCKED, BTN, SYSRESETREQ, LOCKUP;
  logic por0, hrst0, busy0, por1, hrst1, busy1;
  logic [3:0] cause0, cause1;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .POR_CYCLES(8),
                 .SYS_CYCLES(4), .LOCKUP_RESET(1'b1)) u_dut (
    .CLK(clk), .RESET(RESET), .PLL_LOCKED(PLL_LOCKED), .BTN(BTN),
    .SYSRESETREQ(SYSRESETREQ), .LOCKUP(LOCKUP), .PORESETn(por0),
    .HRESETn(hrst0), .RESET_CAUSE(cause0), .SEQ_BUSY(busy0));

  rst_seq_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .POR_CYCLES(8),
                 .SYS_CYCLES(4), .LOCKUP_RESET(1'b0)) u_dut_nolk (
    .CLK(clk), .RESET(RESET), .PLL_LOCKED(PLL_LOCKED), .BTN(BTN),
    .SYSRESETREQ(SYSRESETREQ), .LOCKUP(LOCKUP), .PORESETn(por1),
    .HRESETn(hrst1), .RESET_CAUSE(cause1), .SEQ_BUSY(busy1));

  typedef struct {
    int         c;
    int         u;
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot layout: {PORESETn, HRESETn, RESET_CAUSE, SEQ_BUSY}
  function automatic logic [6:0] st(input logic por, input logic hrst,
                                    input logic [3:0] cause, input logic busy);
    return {por, hrst, cause, busy};
  endfunction

  function automatic logic [6:0] ov(input int u);
    return (u == 0) ? {por0, hrst0, cause0, busy0} : {por1, hrst1, cause1, busy1};
  endfunction

  task automatic check(input string tag, input int u, input logic [6:0] exp_v);
    logic [6:0] got;
    got = ov(u);
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s unit=%0d cyc=%0d got por/hrst/cause/busy=%b/%b/%b/%b expected %b/%b/%b/%b",
             tag, u, cyc, got[6], got[5], got[4:1], got[0],
             exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
    end
  endtask

  task automatic expect_at(input int c, input int u, input string tag, input logic [6:0] v);
    exp_t e;
    e.c = c; e.u = u; e.tag = tag; e.v = v;
    exp_q.push_back(e);
  endtask

  // Lock seen high before edge c+1: PORESETn rises at edge c+11, HRESETn at c+15.
  task automatic expect_cold(input int c, input int u, input logic [3:0] cause, input string tag);
    expect_at(c + 10, u, tag, st(1'b0, 1'b0, cause, 1'b1));
    expect_at(c + 11, u, tag, st(1'b1, 1'b0, cause, 1'b1));
    expect_at(c + 14, u, tag, st(1'b1, 1'b0, cause, 1'b1));
    expect_at(c + 15, u, tag, st(1'b1, 1'b1, cause, 1'b0));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].c == cyc) begin
        check(exp_q[i].tag, exp_q[i].u, exp_q[i].v);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    int c;
    int b;
    RESET = 1'b1; PLL_LOCKED = 1'b0; BTN = 1'b0; SYSRESETREQ = 1'b0; LOCKUP = 1'b0;

    // Reset state and cold start
    tick(3);
    check("reset_state", 0, st(1'b0, 1'b0, 4'b0001, 1'b1));
    check("reset_state", 1, st(1'b0, 1'b0, 4'b0001, 1'b1));
    RESET = 1'b0; PLL_LOCKED = 1'b1; c = cyc;
    expect_cold(c, 0, 4'b0001, "cold_start");
    expect_cold(c, 1, 4'b0001, "cold_start");
    tick(16);

    // Lock loss in RUN for 20 cycles, then relock
    c = cyc; PLL_LOCKED = 1'b0;
    expect_at(c + 2, 0, "lock_loss_pre", st(1'b1, 1'b1, 4'b0001, 1'b0));
    expect_at(c + 3, 0, "lock_loss", st(1'b0, 1'b0, 4'b0010, 1'b1));
    tick(20);
    PLL_LOCKED = 1'b1; c = cyc;
    expect_cold(c, 0, 4'b0010, "relock");
    tick(16);

    // One-cycle lock glitch while in POR_CNT restarts the count
    PLL_LOCKED = 1'b0; tick(5);
    PLL_LOCKED = 1'b1; c = cyc;
    tick(6); PLL_LOCKED = 1'b0;
    tick(1); PLL_LOCKED = 1'b1;
    expect_at(c + 11, 0, "glitch_restart", st(1'b0, 1'b0, 4'b0010, 1'b1));
    expect_cold(c + 7, 0, 4'b0010, "glitch_release");
    tick(16);

    // Bouncing button then settled press
    c = cyc;
    expect_at(c + 20, 0, "bounce_ignored", st(1'b1, 1'b1, 4'b0010, 1'b0));
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) BTN = ~BTN;
      tick(1);
    end
    BTN = 1'b1; c = cyc;
    expect_at(c + 18, 0, "btn_pre", st(1'b1, 1'b1, 4'b0010, 1'b0));
    expect_at(c + 19, 0, "btn_press", st(1'b0, 1'b0, 4'b0100, 1'b1));
    expect_at(c + 19, 1, "btn_press", st(1'b0, 1'b0, 4'b0100, 1'b1));
    tick(25);
    BTN = 1'b0; c = cyc;
    expect_at(c + 18, 0, "btn_hold", st(1'b0, 1'b0, 4'b0100, 1'b1));
    expect_cold(c + 17, 0, 4'b0100, "btn_release");
    expect_cold(c + 17, 1, 4'b0100, "btn_release");
    tick(33);

    // LOCKUP pulse: unit 0 resets the system, unit 1 ignores it
    c = cyc; LOCKUP = 1'b1;
    expect_at(c + 1, 0, "lockup", st(1'b1, 1'b0, 4'b1000, 1'b1));
    expect_at(c + 4, 0, "lockup", st(1'b1, 1'b0, 4'b1000, 1'b1));
    expect_at(c + 5, 0, "lockup", st(1'b1, 1'b1, 4'b1000, 1'b0));
    expect_at(c + 1, 1, "lockup_off", st(1'b1, 1'b1, 4'b0100, 1'b0));
    expect_at(c + 5, 1, "lockup_off", st(1'b1, 1'b1, 4'b0100, 1'b0));
    tick(1); LOCKUP = 1'b0;
    tick(6);

    // SYSRESETREQ pulse in RUN
    c = cyc; SYSRESETREQ = 1'b1;
    for (int u = 0; u < 2; u++) begin
      expect_at(c + 1, u, "sysreq", st(1'b1, 1'b0, 4'b1000, 1'b1));
      expect_at(c + 4, u, "sysreq", st(1'b1, 1'b0, 4'b1000, 1'b1));
      expect_at(c + 5, u, "sysreq", st(1'b1, 1'b1, 4'b1000, 1'b0));
    end
    tick(1); SYSRESETREQ = 1'b0;
    tick(5);

    // Second pulse during SYS_CNT is ignored
    c = cyc; SYSRESETREQ = 1'b1;
    expect_at(c + 4, 0, "sysreq_in_sys", st(1'b1, 1'b0, 4'b1000, 1'b1));
    expect_at(c + 5, 0, "sysreq_in_sys", st(1'b1, 1'b1, 4'b1000, 1'b0));
    expect_at(c + 8, 0, "sysreq_in_sys", st(1'b1, 1'b1, 4'b1000, 1'b0));
    tick(1); SYSRESETREQ = 1'b0;
    tick(1); SYSRESETREQ = 1'b1;
    tick(1); SYSRESETREQ = 1'b0;
    tick(8);

    // Lock loss, button press and SYSRESETREQ on the same edge
    b = cyc; BTN = 1'b1;
    expect_at(b + 18, 0, "simul_pre", st(1'b1, 1'b1, 4'b1000, 1'b0));
    expect_at(b + 19, 0, "simul", st(1'b0, 1'b0, 4'b0010, 1'b1));
    tick(16); PLL_LOCKED = 1'b0;
    tick(2); SYSRESETREQ = 1'b1;
    tick(1); SYSRESETREQ = 1'b0;
    tick(2);
    PLL_LOCKED = 1'b1; c = cyc;
    expect_cold(c, 0, 4'b0010, "simul_relock");
    tick(16);
    BTN = 1'b0; c = cyc;
    expect_at(c + 22, 0, "btn_fall_quiet", st(1'b1, 1'b1, 4'b0010, 1'b0));
    tick(24);

    // Asynchronous reset between edges while in SYS_CNT
    SYSRESETREQ = 1'b1;
    tick(1); SYSRESETREQ = 1'b0;
    tick(1);
    check("pre_async", 0, st(1'b1, 1'b0, 4'b1000, 1'b1));
    #1 RESET = 1'b1;
    #1;
    check("async_reset", 0, st(1'b0, 1'b0, 4'b0001, 1'b1));
    check("async_reset", 1, st(1'b0, 1'b0, 4'b0001, 1'b1));
    tick(2);
    RESET = 1'b0; c = cyc;
    expect_cold(c, 0, 4'b0001, "post_reset");
    tick(17);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain unchecked_entries=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
